// File: rtl/tisc_pkg.sv
// Shared TISC pipeline constants and the MEM-stage state encoding.
package tisc_pkg;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CLEAR = 2'd2
  } mem_state_t;
endpackage

// File: rtl/data_mem.sv
// Data memory: synchronous write port, asynchronous read port.
module data_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Async read sees the pre-edge contents, so a same-cycle load+store returns old data.
  assign rdata = mem[raddr];
endmodule

// File: rtl/mem_stage.sv
// TISC MEM stage: data memory access with optional wait states, MEM/WB registers.
// Define MEM_STAGE_CLEAR_EN to zero the data memory after every reset.
module mem_stage #(
  parameter int ADDR_W      = tisc_pkg::ADDR_W,
  parameter int DATA_W      = tisc_pkg::DATA_W,
  parameter int REG_ADDR_W  = tisc_pkg::REG_ADDR_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ireg_write_addr,
  input  logic                  ireg_write_en,
  input  logic                  imem_to_reg,
  input  logic                  imem_write_en,
  input  logic [ADDR_W-1:0]     idata_write_addr,
  input  logic [DATA_W-1:0]     idata_write_data,
  input  logic [ADDR_W-1:0]     idata_read_addr,
  output logic [REG_ADDR_W-1:0] oreg_write_addr,
  output logic                  oreg_write_en,
  output logic [DATA_W-1:0]     oreg_write_data,
  output logic                  ostall
);
  import tisc_pkg::*;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  mem_state_t        state;
  logic [3:0]        cnt;
  logic              access;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
`ifdef MEM_STAGE_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;
`endif

  assign access = imem_write_en | imem_to_reg;
  assign ostall = (state == CLEAR) | (access & (cnt != WC));

  always_comb begin
    we    = ~rst & ~ostall & imem_write_en;
    waddr = idata_write_addr;
    wdata = idata_write_data;
`ifdef MEM_STAGE_CLEAR_EN
    if (state == CLEAR && !rst) begin
      we    = 1'b1;
      waddr = clr_addr;
      wdata = '0;
    end
`endif
  end

  data_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (idata_read_addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef MEM_STAGE_CLEAR_EN
      state    <= CLEAR;
      clr_addr <= '0;
`else
      state    <= IDLE;
`endif
      cnt             <= '0;
      oreg_write_addr <= '0;
      oreg_write_en   <= 1'b0;
      oreg_write_data <= '0;
    end else begin
      // Stalled cycles push a bubble; address/data hold their last value.
      if (ostall) begin
        oreg_write_en <= 1'b0;
      end else begin
        oreg_write_addr <= ireg_write_addr;
        oreg_write_en   <= ireg_write_en;
        oreg_write_data <= imem_to_reg ? rdata : idata_write_data;
      end

      case (state)
        IDLE:
          if (access && WC != 4'd0) begin
            state <= WAIT;
            cnt   <= 4'd1;
          end
        WAIT:
          if (!access || cnt == WC) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
`ifdef MEM_STAGE_CLEAR_EN
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (&clr_addr) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances at WAIT_CYCLES 0, 2 and 3 on one clock.
module tb_mem_stage;
  typedef struct {
    logic [3:0] ra;
    logic       rwe;
    logic       m2r;
    logic       mwe;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] rda;
  } in_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  in_t        in_s [3];
  logic [3:0] o_ra [3];
  logic       o_we [3];
  logic [7:0] o_wd [3];
  logic       o_st [3];
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst),
    .ireg_write_addr(in_s[0].ra), .ireg_write_en(in_s[0].rwe),
    .imem_to_reg(in_s[0].m2r), .imem_write_en(in_s[0].mwe),
    .idata_write_addr(in_s[0].wa), .idata_write_data(in_s[0].wd),
    .idata_read_addr(in_s[0].rda),
    .oreg_write_addr(o_ra[0]), .oreg_write_en(o_we[0]),
    .oreg_write_data(o_wd[0]), .ostall(o_st[0]));

  mem_stage #(.WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst),
    .ireg_write_addr(in_s[1].ra), .ireg_write_en(in_s[1].rwe),
    .imem_to_reg(in_s[1].m2r), .imem_write_en(in_s[1].mwe),
    .idata_write_addr(in_s[1].wa), .idata_write_data(in_s[1].wd),
    .idata_read_addr(in_s[1].rda),
    .oreg_write_addr(o_ra[1]), .oreg_write_en(o_we[1]),
    .oreg_write_data(o_wd[1]), .ostall(o_st[1]));

  mem_stage #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst),
    .ireg_write_addr(in_s[2].ra), .ireg_write_en(in_s[2].rwe),
    .imem_to_reg(in_s[2].m2r), .imem_write_en(in_s[2].mwe),
    .idata_write_addr(in_s[2].wa), .idata_write_data(in_s[2].wd),
    .idata_read_addr(in_s[2].rda),
    .oreg_write_addr(o_ra[2]), .oreg_write_en(o_we[2]),
    .oreg_write_data(o_wd[2]), .ostall(o_st[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    in_s[k] = '{ra: 4'h0, rwe: 1'b0, m2r: 1'b0, mwe: 1'b0, wa: 8'h00, wd: 8'h00, rda: 8'h00};
  endtask

  task automatic store(input int k, input logic [7:0] a, input logic [7:0] d);
    idle(k);
    in_s[k].mwe = 1'b1; in_s[k].wa = a; in_s[k].wd = d;
  endtask

  task automatic load(input int k, input logic [7:0] a, input logic [3:0] r);
    idle(k);
    in_s[k].m2r = 1'b1; in_s[k].rda = a; in_s[k].ra = r; in_s[k].rwe = 1'b1;
  endtask

  task automatic alu(input int k, input logic [7:0] d, input logic [3:0] r);
    idle(k);
    in_s[k].wd = d; in_s[k].ra = r; in_s[k].rwe = 1'b1;
  endtask

  // Bounded wait for the post-reset clear sweep; expected to last 256 cycles.
  task automatic wait_clear(input int k);
    int n = 0;
    while (o_st[k] === 1'b1 && n < 400) begin
      chk("clear_we", {31'd0, o_we[k]}, 32'd0);
      tick();
      n++;
    end
    chk("clear_len", n, 256);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) idle(k);
    tick(); tick();
    chk("rst_we", {31'd0, o_we[0]}, 32'd0);
    chk("rst_ra", {28'd0, o_ra[0]}, 32'd0);
    chk("rst_wd", {24'd0, o_wd[0]}, 32'd0);
    rst = 1'b0;
    #1;
`ifdef MEM_STAGE_CLEAR_EN
    chk("clear_stall", {31'd0, o_st[0]}, 32'd1);
    wait_clear(0);
    load(0, 8'hFF, 4'd2);
    #1 chk("clr_ld_st", {31'd0, o_st[0]}, 32'd0);
    tick();
    chk("clr_ld_data", {24'd0, o_wd[0]}, 32'h00);
    chk("clr_ld_we", {31'd0, o_we[0]}, 32'd1);
`else
    chk("idle_stall", {31'd0, o_st[0]}, 32'd0);
`endif

    // WAIT=0: store then back-to-back load
    store(0, 8'h10, 8'hA5);
    #1 chk("t1_st_stall", {31'd0, o_st[0]}, 32'd0);
    tick();
    load(0, 8'h10, 4'd3);
    #1 chk("t1_ld_stall", {31'd0, o_st[0]}, 32'd0);
    chk("t1_st_we", {31'd0, o_we[0]}, 32'd0);
    tick();
    chk("t1_we", {31'd0, o_we[0]}, 32'd1);
    chk("t1_ra", {28'd0, o_ra[0]}, 32'd3);
    chk("t1_wd", {24'd0, o_wd[0]}, 32'hA5);

    // ALU pass-through
    alu(0, 8'h3C, 4'd7);
    tick();
    chk("t2_wd", {24'd0, o_wd[0]}, 32'h3C);
    chk("t2_ra", {28'd0, o_ra[0]}, 32'd7);
    chk("t2_we", {31'd0, o_we[0]}, 32'd1);

    // Load+store same address is read-before-write
    store(0, 8'h20, 8'h11);
    tick();
    load(0, 8'h20, 4'd5);
    in_s[0].mwe = 1'b1; in_s[0].wa = 8'h20; in_s[0].wd = 8'h22;
    tick();
    chk("t4_old", {24'd0, o_wd[0]}, 32'h11);
    load(0, 8'h20, 4'd6);
    tick();
    chk("t4_new", {24'd0, o_wd[0]}, 32'h22);
    chk("t4_ra", {28'd0, o_ra[0]}, 32'd6);
    idle(0);
    tick();
    chk("t4_idle_we", {31'd0, o_we[0]}, 32'd0);

    // WAIT=2: preload 0x40, then load with two stall cycles
    store(1, 8'h40, 8'h5A);
    #1 chk("t3_sst0", {31'd0, o_st[1]}, 32'd1);
    tick();
    chk("t3_sst1", {31'd0, o_st[1]}, 32'd1);
    tick();
    chk("t3_sst2", {31'd0, o_st[1]}, 32'd0);
    tick();
    load(1, 8'h40, 4'd9);
    #1 chk("t3_lst0", {31'd0, o_st[1]}, 32'd1);
    tick();
    chk("t3_we_s1", {31'd0, o_we[1]}, 32'd0);
    chk("t3_lst1", {31'd0, o_st[1]}, 32'd1);
    tick();
    chk("t3_we_s2", {31'd0, o_we[1]}, 32'd0);
    chk("t3_lst2", {31'd0, o_st[1]}, 32'd0);
    tick();
    chk("t3_we", {31'd0, o_we[1]}, 32'd1);
    chk("t3_wd", {24'd0, o_wd[1]}, 32'h5A);
    chk("t3_ra", {28'd0, o_ra[1]}, 32'd9);
    alu(1, 8'h66, 4'd2);
    #1 chk("t3_alu_st", {31'd0, o_st[1]}, 32'd0);
    tick();
    chk("t3_alu_wd", {24'd0, o_wd[1]}, 32'h66);
    chk("t3_alu_we", {31'd0, o_we[1]}, 32'd1);

    // WAIT=3: preload 0x30, then reset aborts a second store
    store(2, 8'h30, 8'h01);
    tick(); tick(); tick();
    chk("t5_pre_st", {31'd0, o_st[2]}, 32'd0);
    tick();
    alu(2, 8'h99, 4'd4);
    tick();
    chk("t5_alu_we", {31'd0, o_we[2]}, 32'd1);
    store(2, 8'h30, 8'h77);
    #1 chk("t5_st", {31'd0, o_st[2]}, 32'd1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t5_rst_we", {31'd0, o_we[2]}, 32'd0);
    chk("t5_rst_wd", {24'd0, o_wd[2]}, 32'd0);
    chk("t5_rst_ra", {28'd0, o_ra[2]}, 32'd0);
    idle(2);
    rst = 1'b0;
    #1;
`ifdef MEM_STAGE_CLEAR_EN
    wait_clear(2);
`endif
    load(2, 8'h30, 4'd1);
    tick(); tick(); tick();
    chk("t5_ld_st", {31'd0, o_st[2]}, 32'd0);
    tick();
`ifdef MEM_STAGE_CLEAR_EN
    chk("t5_ld_wd", {24'd0, o_wd[2]}, 32'h00);
`else
    chk("t5_ld_wd", {24'd0, o_wd[2]}, 32'h01);
`endif
    chk("t5_ld_we", {31'd0, o_we[2]}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
